sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 25, byte address width; DATA_WIDTH, 16, data bus width; BE_WIDTH, 2, byteenable width; BURST_WIDTH, 7, burstcount width (max burst 64).
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock for the whole block.
- rst  in  1  reset: asynchronous, active-low.
- mN_address  in  ADDR_WIDTH  requester N address; N = 0, 1 throughout.
- mN_burstcount  in  BURST_WIDTH  requester N burst length in words.
- mN_read, mN_write  in  1 each  requester N read / write request.
- mN_writedata  in  DATA_WIDTH  requester N write data.
- mN_byteenable  in  BE_WIDTH  requester N byte enables.
- mN_waitrequest  out  1  stall to requester N.
- mN_readdatavalid  out  1  read beat valid to requester N.
- mN_readdata  out  DATA_WIDTH  read data to requester N.
- s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable  out  (widths as above)  to the SDRAM controller bus.
- s_waitrequest, s_readdatavalid  in  1 each  from the SDRAM controller.
- s_readdata  in  DATA_WIDTH  from the SDRAM controller.

Function
REQ-003 Block SHALL share one Avalon-style burst slave (SDRAM controller) between two requesters, one whole burst at a time.
REQ-004 FSM states SHALL be IDLE, RD_CMD, RD_DATA, WR.
REQ-005 IDLE: no request pending -> stay in IDLE. Any mN_read or mN_write pending -> register owner, latch burstcount into beat counter, move to RD_CMD (read) or WR (write) next cycle.
REQ-006 Both requesters pending in IDLE -> grant goes to the requester other than last_grant (round-robin); last_grant updates at grant.
REQ-007 A requester asserting read and write together SHALL be treated as a read.
REQ-008 Latched burstcount 0 SHALL be treated as 1.
REQ-009 In IDLE: s_read = s_write = 0; both mN_waitrequest = 1.
REQ-010 In RD_CMD, RD_DATA and WR: s_address, s_burstcount, s_writedata and s_byteenable SHALL be combinationally muxed from the owner.
REQ-011 RD_CMD: s_read = 1, owner waitrequest = s_waitrequest. Cycle with !s_waitrequest = command accepted -> RD_DATA.
REQ-012 RD_DATA: s_read = 0, owner waitrequest = 1.
REQ-013 Beat counter SHALL decrement on each s_readdatavalid in RD_CMD or RD_DATA. Last beat (counter = 1 with valid) -> IDLE.
REQ-014 WR: s_write = owner mN_write, owner waitrequest = s_waitrequest.
REQ-015 Counter SHALL decrement on each accepted beat (mN_write && !s_waitrequest). Last accepted beat -> IDLE.
REQ-016 Non-owner SHALL see waitrequest = 1 at all times and readdatavalid = 0.
REQ-017 mN_readdatavalid = s_readdatavalid only while N is owner in RD_CMD or RD_DATA; otherwise 0.
REQ-018 mN_readdata SHALL be s_readdata broadcast to both requesters.
REQ-019 At least one IDLE cycle SHALL separate consecutive bursts; no grant change mid-burst.
REQ-020 Counter width SHALL be BURST_WIDTH; no wrap below 1 is permitted.

Reset
REQ-021 rst low, at any time including mid-burst, SHALL asynchronously force: state IDLE, counter 0, owner 0, last_grant 1 (requester 0 wins first arbitration).
REQ-022 During and after reset until the next grant: s_read = s_write = 0, both mN_waitrequest = 1, both mN_readdatavalid = 0.

Verification
REQ-023 m0 read, burstcount 4, slave accepts after 2 wait cycles then returns 4 valids -> m0 gets exactly 4 readdatavalid, m1 none, FSM back in IDLE on the cycle after the 4th valid.
REQ-024 m0 and m1 both write in the same cycle after reset, burstcount 2 each -> m0 granted first, 2 beats pass to the slave; then 1 IDLE cycle; then m1 granted, 2 beats pass.
REQ-025 m1 write, burstcount 8, s_waitrequest toggled every other cycle -> exactly 8 accepted beats reach the slave in order; m1_waitrequest mirrors s_waitrequest; m0_waitrequest held at 1.
REQ-026 m0 read, burstcount 0 -> single beat delivered, return to IDLE.
REQ-027 rst pulsed low after 2 of 4 read beats -> s_read = s_write = 0 immediately; after release a pending m1 request is granted only after m0 if both pend.
REQ-028 m0 read and write asserted together, burstcount 1 -> read issued (s_read = 1, s_write = 0).

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Avalon-style burst bus bundle shared by the two requesters and the SDRAM controller port.
// The master modport is the side that issues commands; the slave modport responds to them.
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH  = 25,
    parameter int DATA_WIDTH  = 16,
    parameter int BE_WIDTH    = 2,
    parameter int BURST_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]  address;
    logic [BURST_WIDTH-1:0] burstcount;
    logic                   read;
    logic                   write;
    logic [DATA_WIDTH-1:0]  writedata;
    logic [BE_WIDTH-1:0]    byteenable;
    logic                   waitrequest;
    logic                   readdatavalid;
    logic [DATA_WIDTH-1:0]  readdata;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-requester round-robin arbiter in front of one burst-capable SDRAM controller port.
// Ownership is held for a whole burst; every burst is followed by at least one IDLE cycle.
module sdram_arbiter #(
    parameter int ADDR_WIDTH  = 25,
    parameter int DATA_WIDTH  = 16,
    parameter int BE_WIDTH    = 2,
    parameter int BURST_WIDTH = 7
) (
    input  logic              clk,
    input  logic              rst,
    sdram_arbiter_if.slave    m0,
    sdram_arbiter_if.slave    m1,
    sdram_arbiter_if.master   s
);
    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR} state_t;

    localparam logic [BURST_WIDTH-1:0] ONE = BURST_WIDTH'(1);

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_grant_q, last_grant_d;
    logic [BURST_WIDTH-1:0] count_q, count_d;

    logic                   req0, req1, grant, g_read;
    logic [BURST_WIDTH-1:0] g_bc;

    logic [ADDR_WIDTH-1:0]  own_address;
    logic [BURST_WIDTH-1:0] own_burstcount;
    logic [DATA_WIDTH-1:0]  own_writedata;
    logic [BE_WIDTH-1:0]    own_byteenable;
    logic                   own_write;

    logic                   s_read_c, s_write_c, own_wait, own_rdv;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;
    // Contention goes to whoever did not win last; otherwise the lone requester wins.
    assign grant  = (req0 && req1) ? ~last_grant_q : req1;
    assign g_read = grant ? m1.read       : m0.read;
    assign g_bc   = grant ? m1.burstcount : m0.burstcount;

    assign own_address    = owner_q ? m1.address    : m0.address;
    assign own_burstcount = owner_q ? m1.burstcount : m0.burstcount;
    assign own_writedata  = owner_q ? m1.writedata  : m0.writedata;
    assign own_byteenable = owner_q ? m1.byteenable : m0.byteenable;
    assign own_write      = owner_q ? m1.write      : m0.write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        s_read_c     = 1'b0;
        s_write_c    = 1'b0;
        own_wait     = 1'b1;
        own_rdv      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    count_d      = (g_bc == '0) ? ONE : g_bc;
                    state_d      = g_read ? RD_CMD : WR;
                end
            end
            RD_CMD: begin
                s_read_c = 1'b1;
                own_wait = s.waitrequest;
                own_rdv  = s.readdatavalid;
                // Data may already stream back while the command is still stalled.
                if (s.readdatavalid && count_q == ONE) begin
                    state_d = IDLE;
                end else begin
                    if (s.readdatavalid) count_d = count_q - ONE;
                    if (!s.waitrequest)  state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                own_rdv = s.readdatavalid;
                if (s.readdatavalid) begin
                    if (count_q == ONE) state_d = IDLE;
                    else                count_d = count_q - ONE;
                end
            end
            WR: begin
                s_write_c = own_write;
                own_wait  = s.waitrequest;
                if (own_write && !s.waitrequest) begin
                    if (count_q == ONE) state_d = IDLE;
                    else                count_d = count_q - ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s.address    = own_address;
    assign s.burstcount = own_burstcount;
    assign s.writedata  = own_writedata;
    assign s.byteenable = own_byteenable;
    assign s.read       = s_read_c;
    assign s.write      = s_write_c;

    assign m0.waitrequest   = owner_q ? 1'b1 : own_wait;
    assign m1.waitrequest   = owner_q ? own_wait : 1'b1;
    assign m0.readdatavalid = ~owner_q & own_rdv;
    assign m1.readdatavalid = owner_q & own_rdv;
    assign m0.readdata      = s.readdata;
    assign m1.readdata      = s.readdata;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a constant vector table, directed burst sequences,
// and a randomized run checked against a burst-level reference model.
module tb_sdram_arbiter;
    logic clk;
    logic rst;

    sdram_arbiter_if m0_bus ();
    sdram_arbiter_if m1_bus ();
    sdram_arbiter_if s_bus ();

    sdram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {s_bus.read, s_bus.write, m0_bus.waitrequest, m1_bus.waitrequest,
                m0_bus.readdatavalid, m1_bus.readdatavalid};
    endfunction

    task automatic clear_inputs();
        m0_bus.read = 0; m0_bus.write = 0; m0_bus.burstcount = 0; m0_bus.address = 25'h0000100;
        m0_bus.writedata = 0; m0_bus.byteenable = 2'b11;
        m1_bus.read = 0; m1_bus.write = 0; m1_bus.burstcount = 0; m1_bus.address = 25'h0000200;
        m1_bus.writedata = 0; m1_bus.byteenable = 2'b11;
        s_bus.waitrequest = 1; s_bus.readdatavalid = 0; s_bus.readdata = 16'h5A5A;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        clear_inputs();
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic [1:0] m0_rw;   // {read, write}
        logic [1:0] m1_rw;
        logic [6:0] bc0;
        logic [6:0] bc1;
        logic       sw;
        logic       srdv;
        logic [5:0] exp;     // {s_read, s_write, m0_wait, m1_wait, m0_rdv, m1_rdv}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] a, input logic [1:0] b, input logic [6:0] c0,
                       input logic [6:0] c1, input logic sw, input logic rdv, input logic [5:0] e);
        vec_t v;
        v.rst_n = r; v.m0_rw = a; v.m1_rw = b; v.bc0 = c0; v.bc1 = c1;
        v.sw = sw; v.srdv = rdv; v.exp = e;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    bit      mb_busy, mb_owner, mb_read, mb_cmd_done, mb_last;
    int      mb_left;

    task automatic model_cycle();
        logic rd[2], wr[2];
        logic [6:0] bc[2];
        logic [24:0] ad[2];
        logic [15:0] wd[2];
        logic [1:0]  be[2];
        logic [5:0]  e;
        logic        ew[2], ev[2];
        bit          g, finish;
        rd[0] = m0_bus.read;  wr[0] = m0_bus.write;  bc[0] = m0_bus.burstcount;
        rd[1] = m1_bus.read;  wr[1] = m1_bus.write;  bc[1] = m1_bus.burstcount;
        ad[0] = m0_bus.address; ad[1] = m1_bus.address;
        wd[0] = m0_bus.writedata; wd[1] = m1_bus.writedata;
        be[0] = m0_bus.byteenable; be[1] = m1_bus.byteenable;
        if (!rst) begin
            mb_busy = 0; mb_last = 1;
        end
        for (int n = 0; n < 2; n++) begin
            ew[n] = (mb_busy && mb_owner == n && !(mb_read && mb_cmd_done)) ? s_bus.waitrequest : 1'b1;
            ev[n] = mb_busy && mb_owner == n && mb_read && s_bus.readdatavalid;
        end
        e = {mb_busy && mb_read && !mb_cmd_done, mb_busy && !mb_read && wr[mb_owner],
             ew[0], ew[1], ev[0], ev[1]};
        chk("rand_flags", 64'(flags()), 64'(e));
        chk("rand_rdata", 64'({m0_bus.readdata, m1_bus.readdata}), 64'({s_bus.readdata, s_bus.readdata}));
        if (mb_busy)
            chk("rand_bus", {s_bus.address, s_bus.burstcount, s_bus.writedata, s_bus.byteenable},
                {ad[mb_owner], bc[mb_owner], wd[mb_owner], be[mb_owner]});
        if (!rst) return;
        if (!mb_busy) begin
            if (rd[0] || wr[0] || rd[1] || wr[1]) begin
                g = ((rd[0] || wr[0]) && (rd[1] || wr[1])) ? !mb_last : (rd[1] || wr[1]);
                mb_busy = 1; mb_owner = g; mb_last = g; mb_read = rd[g];
                mb_cmd_done = 0;
                mb_left = (bc[g] == 0) ? 1 : int'(bc[g]);
            end
        end else if (mb_read) begin
            finish = s_bus.readdatavalid && mb_left == 1;
            if (finish) mb_busy = 0;
            else begin
                if (s_bus.readdatavalid) mb_left--;
                if (!s_bus.waitrequest) mb_cmd_done = 1;
            end
        end else if (wr[mb_owner] && !s_bus.waitrequest) begin
            if (mb_left == 1) mb_busy = 0;
            else mb_left--;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int k, n_acc, acc_cyc[$];
        logic [15:0] got[$];
        logic [15:0] want[4];

        rst = 0;
        clear_inputs();

        // ---- table: read burst of 4 with 2 wait states, m1 read bc=0, read+write together ----
        add(0, 2'b00, 2'b00, 0, 0, 1, 0, 6'b001100);
        add(1, 2'b10, 2'b00, 4, 0, 1, 0, 6'b001100);
        add(1, 2'b10, 2'b00, 4, 0, 1, 0, 6'b101100);
        add(1, 2'b10, 2'b00, 4, 0, 1, 0, 6'b101100);
        add(1, 2'b10, 2'b00, 4, 0, 0, 0, 6'b100100);
        add(1, 2'b00, 2'b00, 0, 0, 0, 1, 6'b001110);
        add(1, 2'b00, 2'b00, 0, 0, 0, 1, 6'b001110);
        add(1, 2'b00, 2'b00, 0, 0, 0, 0, 6'b001100);
        add(1, 2'b00, 2'b00, 0, 0, 0, 1, 6'b001110);
        add(1, 2'b00, 2'b00, 0, 0, 0, 1, 6'b001110);
        add(1, 2'b00, 2'b10, 0, 0, 0, 0, 6'b001100);
        add(1, 2'b00, 2'b10, 0, 0, 0, 0, 6'b101000);
        add(1, 2'b00, 2'b00, 0, 0, 0, 1, 6'b001101);
        add(1, 2'b11, 2'b00, 1, 0, 0, 1, 6'b001100);
        add(1, 2'b11, 2'b00, 1, 0, 0, 0, 6'b100100);
        add(1, 2'b00, 2'b00, 0, 0, 0, 1, 6'b001110);
        add(1, 2'b00, 2'b00, 0, 0, 0, 1, 6'b001100);
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst_n;
            {m0_bus.read, m0_bus.write} = vecs[i].m0_rw;
            {m1_bus.read, m1_bus.write} = vecs[i].m1_rw;
            m0_bus.burstcount = vecs[i].bc0;
            m1_bus.burstcount = vecs[i].bc1;
            s_bus.waitrequest = vecs[i].sw;
            s_bus.readdatavalid = vecs[i].srdv;
            s_bus.readdata = 16'(16'h1000 + i);
            #1;
            chk($sformatf("table_row%0d", i), 64'(flags()), 64'(vecs[i].exp));
            chk($sformatf("table_rdata%0d", i), 64'({m0_bus.readdata, m1_bus.readdata}),
                64'({16'(16'h1000 + i), 16'(16'h1000 + i)}));
        end
        $display("table: %0d rows applied", vecs.size());

        // ---- both write bc=2 at once: m0 first, one idle cycle, then m1 ----
        reset_dut();
        want = '{16'hA000, 16'hA001, 16'hB000, 16'hB001};
        k = 0; n_acc = 0;
        begin
            int k1 = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                m0_bus.write = (k < 2);  m0_bus.burstcount = 2; m0_bus.writedata = 16'(16'hA000 + k);
                m1_bus.write = (k1 < 2); m1_bus.burstcount = 2; m1_bus.writedata = 16'(16'hB000 + k1);
                s_bus.waitrequest = 0;
                #1;
                if (s_bus.write && !s_bus.waitrequest) begin
                    got.push_back(s_bus.writedata);
                    acc_cyc.push_back(c);
                end
                if (m0_bus.write && !m0_bus.waitrequest) k++;
                if (m1_bus.write && !m1_bus.waitrequest) k1++;
            end
        end
        chk("rr_write_beats", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_write_data%0d", i), 64'((i < got.size()) ? got[i] : 16'hxxxx), 64'(want[i]));
        if (acc_cyc.size() == 4)
            chk("rr_idle_gap", 64'(acc_cyc[2] - acc_cyc[1]), 64'd2);
        else
            chk("rr_idle_gap_count", 64'(acc_cyc.size()), 64'd4);
        $display("seq: dual write round-robin, %0d beats seen", got.size());

        // ---- m1 write bc=8 with toggling slave stall ----
        reset_dut();
        k = 0; n_acc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            m1_bus.write = (k < 8); m1_bus.burstcount = 8; m1_bus.writedata = 16'(16'hC000 + k);
            s_bus.waitrequest = c[0];
            #1;
            chk("wr8_m0_wait", 64'(m0_bus.waitrequest), 64'd1);
            if (c > 0 && k < 8) chk("wr8_m1_mirror", 64'(m1_bus.waitrequest), 64'(s_bus.waitrequest));
            if (s_bus.write && !s_bus.waitrequest) begin
                chk("wr8_data", 64'(s_bus.writedata), 64'(16'hC000 + n_acc));
                n_acc++;
            end
            if (m1_bus.write && !m1_bus.waitrequest) k++;
        end
        chk("wr8_beats", 64'(n_acc), 64'd8);
        $display("seq: m1 burst write of 8, %0d beats accepted", n_acc);

        // ---- reset mid read burst, then both pend: m0 wins ----
        reset_dut();
        @(negedge clk);
        m0_bus.read = 1; m0_bus.burstcount = 4; m0_bus.address = 25'h0000ABC;
        m1_bus.address = 25'h0000DEF;
        #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            s_bus.waitrequest = 1; s_bus.readdatavalid = 1;
            #1;
            chk("rst_pre_read", 64'({s_bus.read, m0_bus.readdatavalid}), 64'(2'b11));
        end
        @(negedge clk);
        rst = 0; m1_bus.read = 1; m1_bus.burstcount = 1;
        #1;
        chk("rst_async_flags", 64'(flags()), 64'(6'b001100));
        @(negedge clk);
        rst = 1; s_bus.readdatavalid = 0; s_bus.waitrequest = 0;
        #1;
        chk("rst_release_idle", 64'(flags()), 64'(6'b001100));
        @(negedge clk);
        #1;
        chk("rst_regrant_m0", 64'(flags()), 64'(6'b100100));
        chk("rst_regrant_addr", 64'(s_bus.address), 64'(25'h0000ABC));
        $display("seq: reset mid-burst, re-grant checked");

        // ---- randomized run against reference model ----
        reset_dut();
        mb_busy = 0; mb_last = 1; mb_owner = 0; mb_read = 0; mb_cmd_done = 0; mb_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) != 0);
            m0_bus.read = ($urandom_range(0, 3) == 0);  m0_bus.write = ($urandom_range(0, 3) == 0);
            m1_bus.read = ($urandom_range(0, 3) == 0);  m1_bus.write = ($urandom_range(0, 3) == 0);
            m0_bus.burstcount = 7'($urandom_range(0, 5)); m1_bus.burstcount = 7'($urandom_range(0, 5));
            m0_bus.address = 25'($urandom); m1_bus.address = 25'($urandom);
            m0_bus.writedata = 16'($urandom); m1_bus.writedata = 16'($urandom);
            m0_bus.byteenable = 2'($urandom); m1_bus.byteenable = 2'($urandom);
            s_bus.waitrequest = ($urandom_range(0, 2) == 0);
            s_bus.readdatavalid = 1'($urandom_range(0, 1));
            s_bus.readdata = 16'($urandom);
            #1;
            model_cycle();
        end
        $display("random: 3000 cycles applied");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
